// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses in a small FIFO for decode, and handles PC redirects by flushing
// the buffer and dropping responses to requests already in flight.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [31:0]   fifo_q [DEPTH];
  logic [31:0]   fifo_d [DEPTH];

  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          pop;
  logic          drop_rsp;
  logic          push;
  logic [31:0]   redirect_pc_a;

  // Requests in flight plus buffered words bound the FIFO, so a slot is
  // always reserved for every outstanding response.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = ~reset & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign inst_valid     = ~reset & (count_q != '0);
  assign inst           = fifo_q[rd_ptr_q];
  assign inst_pc        = head_pc_q;

  assign req_fire       = imem_req_valid & imem_req_ready;
  assign pop            = inst_valid & inst_ready;
  assign drop_rsp       = imem_rsp_valid & (discard_q != '0);
  assign push           = imem_rsp_valid & ~drop_rsp & ~redirect_valid;
  assign redirect_pc_a  = redirect_pc & 32'hFFFF_FFFC;

  // Next-state: redirect flushes everything; otherwise fetch, response and pop
  // update independently.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    fifo_d     = fifo_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_a;
      head_pc_d  = redirect_pc_a;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // Every request still outstanding after this cycle returns stale data.
      inflight_d = inflight_q - CW'(imem_rsp_valid);
      discard_d  = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (drop_rsp) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        fifo_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        head_pc_d = head_pc_q + 32'd4;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC_A;
      head_pc_q  <= RESET_PC_A;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Buffer storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic against a queue-based reference model and a memory model.
module tb_instruction_fetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_rsp_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_due = -1;

  // Memory model: pending responses in order
  mem_rsp_t    mem_q[$];
  // Reference model of the fetch unit
  logic [31:0] m_fetch;
  logic [31:0] m_head;
  logic [31:0] m_q[$];
  int          m_inflight;
  int          m_discard;
  // Observation logs for directed checks
  logic [31:0] fire_log[$];
  logic [31:0] pop_log[$];
  logic        iv_log[$];

  // Memory contents: odd multiplier makes every address map to a distinct word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      @(posedge clk);
      cyc++;
      #1;
    end
    check("rst_req_valid_end", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid_end", 32'(inst_valid), 32'd0);
    reset = 1'b0;
    mem_q.delete();
    last_due   = -1;
    m_fetch    = RESET_PC;
    m_head     = RESET_PC;
    m_q.delete();
    m_inflight = 0;
    m_discard  = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic cycle(input bit rdy, input bit irdy, input bit redir,
                       input logic [31:0] rpc, input int lmin, input int lmax);
    bit          rsp;
    bit          exp_req;
    bit          exp_iv;
    bit          m_fire;
    bit          m_pop;
    logic [31:0] rdata;
    logic [31:0] tgt;
    int          lat;
    int          due;

    rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    if (rsp) begin
      rdata = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      rdata = $urandom;
    end
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;

    exp_req = !redir && ((m_inflight + m_q.size()) < DEPTH);
    exp_iv  = (m_q.size() != 0);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    check("req_addr_lsb", 32'(imem_req_addr[1:0]), 32'd0);
    if (exp_req) check("req_addr", imem_req_addr, m_fetch);
    check("inst_valid", 32'(inst_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("inst_pc", inst_pc, m_head);
      check("inst", inst, m_q[0]);
      check("inst_vs_mem", inst, mem_word(inst_pc));
    end
    if (rsp) check("rsp_with_inflight", 32'(m_inflight != 0), 32'd1);

    iv_log.push_back(inst_valid);
    if (inst_valid && irdy) pop_log.push_back(inst_pc);
    if (imem_req_valid && rdy) begin
      lat = int'($urandom_range(lmax, lmin));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{mem_word(imem_req_addr), due});
      fire_log.push_back(imem_req_addr);
    end

    m_fire = exp_req && rdy;
    m_pop  = exp_iv && irdy;
    if (redir) begin
      tgt = {rpc[31:2], 2'b00};
      if (rsp) m_inflight--;
      m_discard = m_inflight;
      m_q.delete();
      m_fetch = tgt;
      m_head  = tgt;
    end else begin
      if (m_fire) begin
        m_fetch += 32'd4;
        m_inflight++;
      end
      if (m_pop) begin
        void'(m_q.pop_front());
        m_head += 32'd4;
      end
      if (rsp) begin
        m_inflight--;
        if (m_discard > 0) m_discard--;
        else begin
          m_q.push_back(rdata);
          check("no_overflow", 32'(m_q.size() <= DEPTH), 32'd1);
        end
      end
    end

    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_logs();
    fire_log.delete();
    pop_log.delete();
    iv_log.delete();
  endtask

  initial begin
    // Reset release, 1-cycle memory, streaming decode
    do_reset(2);
    clear_logs();
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 32'h0, 1, 1);
    for (int k = 0; k < 10; k++) check("stream_fetch_addr", fire_log[k], 32'(4 * k));
    for (int k = 0; k < 10; k++) check("stream_pop_pc", pop_log[k], 32'(4 * k));
    for (int k = 2; k < 12; k++) check("stream_throughput", 32'(iv_log[k]), 32'd1);

    // Decode stalled: exactly DEPTH requests, head held, then gapless drain
    do_reset(1);
    clear_logs();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 32'h0, 1, 1);
    check("stall_req_count", 32'(fire_log.size()), 32'(DEPTH));
    check("stall_inst_valid", 32'(inst_valid), 32'd1);
    check("stall_inst_pc", inst_pc, 32'h0);
    clear_logs();
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 32'h0, 1, 1);
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", 32'(iv_log[k]), 32'd1);
      check("drain_pc", pop_log[k], 32'(4 * k));
    end

    // Redirect with two requests in flight
    do_reset(1);
    cycle(1, 1, 0, 32'h0, 3, 3);
    cycle(1, 1, 0, 32'h0, 3, 3);
    cycle(1, 1, 1, 32'h0000_1002, 3, 3);
    clear_logs();
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 32'h0, 3, 3);
    check("redir_first_addr", fire_log[0], 32'h0000_1000);
    check("redir_first_pc", pop_log[0], 32'h0000_1000);
    check("redir_second_pc", pop_log[1], 32'h0000_1004);

    // Redirect coinciding with a response and a pop
    do_reset(1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 32'h0, 1, 1);
    check("coincide_rsp_pending", 32'(mem_q.size() != 0 && mem_q[0].due <= cyc), 32'd1);
    clear_logs();
    cycle(1, 1, 1, 32'h0000_2000, 1, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 32'h0, 1, 1);
    check("coincide_pop_pc", pop_log[0], 32'h0000_0008);
    check("coincide_next_pc", pop_log[1], 32'h0000_2000);

    // Address wrap at the top of memory
    cycle(1, 1, 1, 32'hFFFF_FFF8, 1, 1);
    clear_logs();
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 32'h0, 1, 1);
    check("wrap_addr0", fire_log[0], 32'hFFFF_FFF8);
    check("wrap_addr1", fire_log[1], 32'hFFFF_FFFC);
    check("wrap_addr2", fire_log[2], 32'h0000_0000);
    check("wrap_pc2", pop_log[2], 32'h0000_0000);

    // Back-to-back redirects: the last one wins
    cycle(1, 1, 1, 32'h0000_3000, 2, 2);
    cycle(1, 1, 1, 32'h0000_4005, 2, 2);
    clear_logs();
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 32'h0, 2, 2);
    check("b2b_first_pc", pop_log[0], 32'h0000_4004);
    check("b2b_first_addr", fire_log[0], 32'h0000_4004);

    // Random traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0, $urandom, 1, 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
